// File: rtl/dma_req_splitter.sv
// dma_req_splitter: splits one DMA request into chunks that never cross a
// 2^BOUND_BITS-byte address boundary. Each chunk is written as one packed
// word {last, ctx, len, addr} into a downstream FIFO.
module dma_req_splitter #(
   parameter int ADDR_BITS  = 64,
   parameter int LEN_BITS   = 32,
   parameter int CTX_BITS   = 16,
   parameter int BOUND_BITS = 12,
   localparam int DATA_BITS = 1 + CTX_BITS + LEN_BITS + ADDR_BITS
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 s_req_valid,
   output logic                 s_req_ready,
   input  logic [ADDR_BITS-1:0] s_req_addr,
   input  logic [LEN_BITS-1:0]  s_req_len,
   input  logic [CTX_BITS-1:0]  s_req_ctx,
   output logic                 fifo_wr,
   input  logic                 fifo_ready_wr,
   output logic [DATA_BITS-1:0] fifo_data,
   output logic                 busy,
   output logic [31:0]          chunk_cnt
);

   typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_t;

   // One full boundary window, 2^BOUND_BITS, held in BOUND_BITS+1 bits.
   localparam logic [BOUND_BITS:0] WINDOW = {1'b1, {BOUND_BITS{1'b0}}};

   state_t               state_reg, state_next;
   logic [ADDR_BITS-1:0] addr_reg;
   logic [LEN_BITS-1:0]  rem_reg;
   logic [CTX_BITS-1:0]  ctx_reg;
   logic [31:0]          cnt_reg;

   logic [BOUND_BITS:0]  room;
   logic [LEN_BITS-1:0]  room_ext;
   logic                 chunk_last;
   logic [LEN_BITS-1:0]  chunk_len;
   logic                 accept;
   logic                 write;

   // Current chunk: bytes left in this window versus bytes left in the request.
   always_comb begin
      room       = WINDOW - {1'b0, addr_reg[BOUND_BITS-1:0]};
      room_ext   = LEN_BITS'(room);
      chunk_last = (rem_reg <= room_ext);
      chunk_len  = chunk_last ? rem_reg : room_ext;
   end

   // Handshake and write qualifiers; both are masked while reset is held.
   always_comb begin
      accept = aresetn && (state_reg == IDLE) && s_req_valid;
      write  = aresetn && (state_reg == SPLIT) && fifo_ready_wr;
   end

   // State register.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: leave IDLE on a handshake, leave SPLIT on the last write.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = SPLIT;
         SPLIT:   if (write && chunk_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers: load on handshake, advance by one chunk per write.
   // With no write pending everything holds, so fifo_data stays stable.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         addr_reg <= '0;
         rem_reg  <= '0;
         ctx_reg  <= '0;
         cnt_reg  <= '0;
      end else if (accept) begin
         addr_reg <= s_req_addr;
         rem_reg  <= s_req_len;
         ctx_reg  <= s_req_ctx;
      end else if (write) begin
         addr_reg <= addr_reg + ADDR_BITS'(chunk_len);
         rem_reg  <= rem_reg - chunk_len;
         cnt_reg  <= cnt_reg + 32'd1;
      end
   end

   // Outputs: everything is forced low while reset is asserted.
   always_comb begin
      s_req_ready = aresetn && (state_reg == IDLE);
      busy        = aresetn && (state_reg == SPLIT);
      fifo_wr     = write;
      fifo_data   = '0;
      if (aresetn && (state_reg == SPLIT)) begin
         fifo_data = {chunk_last, ctx_reg, chunk_len, addr_reg};
      end
      chunk_cnt   = cnt_reg;
   end

endmodule

// File: tb/tb_dma_req_splitter.sv
// Directed testbench for dma_req_splitter: drives requests on the falling
// edge, checks outputs just after, and commits on the rising edge.
module tb_dma_req_splitter;

   localparam int AB = 64;
   localparam int LB = 32;
   localparam int CB = 16;
   localparam int DB = 1 + CB + LB + AB;

   logic          aclk;
   logic          aresetn;
   logic          s_req_valid;
   logic          s_req_ready;
   logic [AB-1:0] s_req_addr;
   logic [LB-1:0] s_req_len;
   logic [CB-1:0] s_req_ctx;
   logic          fifo_wr;
   logic          fifo_ready_wr;
   logic [DB-1:0] fifo_data;
   logic          busy;
   logic [31:0]   chunk_cnt;

   int tests_run = 0;
   int tests_failed = 0;

   dma_req_splitter dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_req_valid   (s_req_valid),
      .s_req_ready   (s_req_ready),
      .s_req_addr    (s_req_addr),
      .s_req_len     (s_req_len),
      .s_req_ctx     (s_req_ctx),
      .fifo_wr       (fifo_wr),
      .fifo_ready_wr (fifo_ready_wr),
      .fifo_data     (fifo_data),
      .busy          (busy),
      .chunk_cnt     (chunk_cnt)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   function automatic logic [DB-1:0] mk(input logic last, input logic [CB-1:0] ctx,
                                        input logic [LB-1:0] len, input logic [AB-1:0] addr);
      return {last, ctx, len, addr};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one full cycle, ending on the next falling edge.
   task automatic tick();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   // Present a request, confirm acceptance, and land in the first SPLIT cycle.
   task automatic send(input string tag, input logic [AB-1:0] a, input logic [LB-1:0] l,
                       input logic [CB-1:0] c);
      s_req_valid = 1'b1;
      s_req_addr  = a;
      s_req_len   = l;
      s_req_ctx   = c;
      #1;
      chk({tag, ".ready"}, 128'(s_req_ready), 128'(1'b1));
      tick();
      s_req_valid = 1'b0;
      s_req_addr  = '0;
      s_req_len   = '0;
      s_req_ctx   = '0;
      #1;
      chk({tag, ".busy"}, 128'(busy), 128'(1'b1));
      $display("[TB] %s: request addr=%h len=%h ctx=%h accepted", tag, a, l, c);
   endtask

   // Expect one chunk write in the current cycle, then commit it.
   task automatic chunk(input string tag, input logic last, input logic [CB-1:0] c,
                        input logic [LB-1:0] l, input logic [AB-1:0] a);
      #1;
      chk({tag, ".wr"}, 128'(fifo_wr), 128'(1'b1));
      chk({tag, ".data"}, 128'(fifo_data), 128'(mk(last, c, l, a)));
      $display("[TB] %s: chunk addr=%h len=%h last=%0d", tag, a, l, last);
      tick();
   endtask

   initial begin
      aresetn       = 1'b0;
      s_req_valid   = 1'b0;
      s_req_addr    = '0;
      s_req_len     = '0;
      s_req_ctx     = '0;
      fifo_ready_wr = 1'b1;
      @(negedge aclk);
      tick();
      #1;
      chk("rst.ready", 128'(s_req_ready), 128'(1'b0));
      chk("rst.wr",    128'(fifo_wr),     128'(1'b0));
      chk("rst.busy",  128'(busy),        128'(1'b0));
      chk("rst.data",  128'(fifo_data),   128'(0));
      chk("rst.cnt",   128'(chunk_cnt),   128'(0));
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("rel.ready", 128'(s_req_ready), 128'(1'b1));
      $display("[TB] reset: released");

      // 1: aligned single chunk
      send("t1", 64'h1000, 32'h1000, 16'h00A5);
      chunk("t1.c0", 1'b1, 16'h00A5, 32'h1000, 64'h1000);
      #1;
      chk("t1.ready", 128'(s_req_ready), 128'(1'b1));
      chk("t1.busy",  128'(busy),        128'(1'b0));
      chk("t1.cnt",   128'(chunk_cnt),   128'(1));

      // 2: short crossing, back-to-back chunks, ready 3 cycles after handshake
      @(negedge aclk);
      send("t2", 64'h0FF0, 32'h30, 16'h005A);
      chunk("t2.c0", 1'b0, 16'h005A, 32'h10, 64'h0FF0);
      chunk("t2.c1", 1'b1, 16'h005A, 32'h20, 64'h1000);
      #1;
      chk("t2.ready", 128'(s_req_ready), 128'(1'b1));
      chk("t2.cnt",   128'(chunk_cnt),   128'(3));

      // 3+4: multi-chunk with 3 cycles of backpressure after the first chunk;
      // a request presented while splitting must be ignored
      @(negedge aclk);
      send("t3", 64'h0800, 32'h2000, 16'h0033);
      chunk("t3.c0", 1'b0, 16'h0033, 32'h800, 64'h0800);
      fifo_ready_wr = 1'b0;
      s_req_valid   = 1'b1;
      s_req_addr    = 64'hDEAD_0000;
      s_req_len     = 32'h5;
      s_req_ctx     = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t4.wr",    128'(fifo_wr),     128'(1'b0));
         chk("t4.data",  128'(fifo_data),   128'(mk(1'b0, 16'h0033, 32'h1000, 64'h1000)));
         chk("t4.ready", 128'(s_req_ready), 128'(1'b0));
         $display("[TB] t4: stall cycle %0d", i);
         tick();
      end
      s_req_valid   = 1'b0;
      s_req_addr    = '0;
      s_req_len     = '0;
      s_req_ctx     = '0;
      fifo_ready_wr = 1'b1;
      chunk("t3.c1", 1'b0, 16'h0033, 32'h1000, 64'h1000);
      chunk("t3.c2", 1'b1, 16'h0033, 32'h800,  64'h2000);
      #1;
      chk("t3.ready", 128'(s_req_ready), 128'(1'b1));
      chk("t3.cnt",   128'(chunk_cnt),   128'(6));

      // 5a: zero length
      @(negedge aclk);
      send("t5a", 64'h1234, 32'h0, 16'h0011);
      chunk("t5a.c0", 1'b1, 16'h0011, 32'h0, 64'h1234);
      #1;
      chk("t5a.cnt", 128'(chunk_cnt), 128'(7));

      // 5b: address wrap past 2^64
      @(negedge aclk);
      send("t5b", 64'hFFFF_FFFF_FFFF_FF00, 32'h200, 16'h0022);
      chunk("t5b.c0", 1'b0, 16'h0022, 32'h100, 64'hFFFF_FFFF_FFFF_FF00);
      chunk("t5b.c1", 1'b1, 16'h0022, 32'h100, 64'h0);
      #1;
      chk("t5b.cnt", 128'(chunk_cnt), 128'(9));

      // 6: reset after the first chunk of a multi-chunk request
      @(negedge aclk);
      send("t6", 64'h0800, 32'h2000, 16'h0044);
      chunk("t6.c0", 1'b0, 16'h0044, 32'h800, 64'h0800);
      aresetn = 1'b0;
      #1;
      chk("t6.rst.wr",    128'(fifo_wr),     128'(1'b0));
      chk("t6.rst.ready", 128'(s_req_ready), 128'(1'b0));
      chk("t6.rst.data",  128'(fifo_data),   128'(0));
      tick();
      #1;
      chk("t6.rst.cnt",   128'(chunk_cnt),   128'(0));
      chk("t6.rst.busy",  128'(busy),        128'(1'b0));
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      chk("t6.rel.ready", 128'(s_req_ready), 128'(1'b1));
      chk("t6.rel.wr",    128'(fifo_wr),     128'(1'b0));
      chk("t6.rel.busy",  128'(busy),        128'(1'b0));
      $display("[TB] t6: reset mid-request released");
      @(negedge aclk);
      send("t6n", 64'h0FF8, 32'h10, 16'h0055);
      chunk("t6n.c0", 1'b0, 16'h0055, 32'h8, 64'h0FF8);
      chunk("t6n.c1", 1'b1, 16'h0055, 32'h8, 64'h1000);
      #1;
      chk("t6n.ready", 128'(s_req_ready), 128'(1'b1));
      chk("t6n.cnt",   128'(chunk_cnt),   128'(2));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dma_req_splitter.md
# dma_req_splitter

Upstream feeder for the RoCE stack's generic synchronous FIFO. Accepts one DMA request (virtual address, byte length, opaque context) per handshake and splits it into chunks that never cross a 2^BOUND_BITS-byte address boundary. Each chunk is written as one packed word through the FIFO's `wr` / `ready_wr` / `data_in` port.

## Interface
- `ADDR_BITS`, 64, virtual address width
- `LEN_BITS`, 32, byte length width
- `CTX_BITS`, 16, opaque context width, copied unchanged into every chunk
- `BOUND_BITS`, 12, boundary exponent (4 KiB); chunk length ≤ 2^BOUND_BITS; requires BOUND_BITS < LEN_BITS
- `DATA_BITS`, 1+CTX_BITS+LEN_BITS+ADDR_BITS (derived; not overridden)

Ports:
- `aclk`  in  1  clock; the block has one clock
- `aresetn`  in  1  reset, synchronous, active-low
- `s_req_valid`  in  1  request valid
- `s_req_ready`  out  1  request accepted when valid and ready are both high
- `s_req_addr`  in  ADDR_BITS  start address
- `s_req_len`  in  LEN_BITS  byte length; 0 is legal
- `s_req_ctx`  in  CTX_BITS  context
- `fifo_wr`  out  1  write strobe to the FIFO
- `fifo_ready_wr`  in  1  FIFO not full
- `fifo_data`  out  DATA_BITS  {last, ctx, len, addr}, with MSB first
- `busy`  out  1  high while a request is being split
- `chunk_cnt`  out  32  total chunks written since reset; wraps at 2^32

## Operation
The block has two states, IDLE and SPLIT.

IDLE:
- `s_req_ready` = 1.
- On handshake, latch `cur_addr` ← `s_req_addr`, `rem` ← `s_req_len`, `ctx` ← `s_req_ctx`, then go to SPLIT.

SPLIT:
- `s_req_ready` = 0 and `busy` = 1.
- The chunk is computed combinationally from the registered `cur_addr` and `rem`:
  - `room` = 2^BOUND_BITS − `cur_addr[BOUND_BITS-1:0]`, computed in BOUND_BITS+1 bits, range 1..2^BOUND_BITS.
  - `last` = (`rem` ≤ `room`).
  - `len` = `last` ? `rem` : `room`, zero-extended to LEN_BITS.
  - `fifo_data` = {`last`, `ctx`, `len`, `cur_addr`}.
- `fifo_wr` = `fifo_ready_wr`. A write is never issued into a full FIFO.
- On a write:
  - `cur_addr` ← `cur_addr` + `len`, modulo 2^ADDR_BITS; wrap is silent.
  - `rem` ← `rem` − `len`.
  - `chunk_cnt` increments.
  - If `last`, go to IDLE.
- When `fifo_ready_wr` = 0: `fifo_wr` = 0 and all registers hold, so `fifo_data` is stable.

Boundary conditions:
- **Zero-length request:** emits exactly one word with len 0 and last = 1.
- **Aligned start:** the first chunk is a full 2^BOUND_BITS bytes, unless `rem` is smaller.
- **Request fits inside one boundary window:** one word with last = 1.
- **Inputs in SPLIT:** `s_req_*` are ignored and no request is accepted.

Reset (`aresetn` = 0 at a clock edge):
- State goes to IDLE; `cur_addr`, `rem`, `ctx` and `chunk_cnt` go to 0.
- While `aresetn` = 0: `s_req_ready` = 0, `fifo_wr` = 0, `busy` = 0, `fifo_data` = 0, `chunk_cnt` = 0.
- A reset in the middle of SPLIT discards the rest of the request with no further writes.

## Timing
- All state is registered on `posedge aclk`.
- `fifo_wr` and `fifo_data` are combinational from the registers and `fifo_ready_wr`.
- **Request to first write:** handshake at edge t; the first `fifo_wr` can be high in the cycle after edge t, so the earliest first write commits at edge t+1.
- **Throughput:** one chunk per cycle while `fifo_ready_wr` = 1.
- **Occupancy:** an N-chunk request occupies N+1 cycles from handshake to the next `s_req_ready`, without backpressure.
- **Return to IDLE:** the cycle after the edge that commits the last chunk, `s_req_ready` = 1 and `busy` = 0.
- **No overlap:** handshake and last-chunk write never happen in the same cycle.
- **Output after reset:** the first cycle after `aresetn` rises, `s_req_ready` = 1.
- **Critical path:** the `room`/`len` compare-and-select plus the `cur_addr` adder; these must meet timing at the stack clock without extra pipelining.

## Test plan
1. **Aligned single chunk:** addr 0x1000, len 0x1000, ctx 0x00A5 → one word {1, 0x00A5, 0x1000, 0x1000}; `chunk_cnt` = 1.
2. **Short crossing:** addr 0x0FF0, len 0x30 → {0, ctx, 0x10, 0x0FF0}, then {1, ctx, 0x20, 0x1000} on consecutive cycles; `s_req_ready` is high 3 cycles after the handshake.
3. **Multi-chunk:** addr 0x0800, len 0x2000 → three words:
   - (0x0800, 0x800, last 0)
   - (0x1000, 0x1000, last 0)
   - (0x2000, 0x800, last 1)
4. **Backpressure:** during test 3, hold `fifo_ready_wr` = 0 for 3 cycles after the first chunk → `fifo_wr` = 0 and `fifo_data` stays (0x1000, 0x1000, 0) throughout; no chunk is lost or duplicated; the total is 3 words.
5. **Zero length and address wrap:**
   - addr 0x1234, len 0 → one word (0x1234, 0, last 1).
   - addr 0xFFFF_FFFF_FFFF_FF00, len 0x200 → (…FF00, 0x100, 0), then (0x0, 0x100, 1).
6. **Reset mid-operation:** start test 3, assert `aresetn` = 0 after the first chunk → no further `fifo_wr`; `chunk_cnt` = 0; `s_req_ready` = 1 one cycle after release; a new request then splits correctly.
